writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Writer side of the register-file write port. It accepts completed results from the execute stage and drives the single register-file write port (DM_addr_write / DM_data_write / DM_sig_write). ALU results are written back directly. Load results are fetched over a variable-latency memory request/acknowledge handshake, with a timeout. While a load is outstanding, the block flags read-after-write hazards on decode-stage read addresses, because forwarding cannot cover data that has not yet returned.

Parameters:
DATA_W, 8, register and memory data width
ADDR_W, 2, register address width (4 registers)
MEM_AW, 8, memory address width
LOAD_TIMEOUT, 15, maximum cycles waited for MEM_ack before a load is aborted
FAULT_DATA, 8'hFF, value written to the destination register on a load timeout

Ports:
sig_clk  in  1  clock, all state on rising edge
sig_rst_n  in  1  asynchronous active-low reset
EX_valid  in  1  execute stage presents a result
EX_ready  out  1  block accepts EX_* this cycle
EX_is_load  in  1  1 = memory load, 0 = ALU result
EX_addr_dest  in  ADDR_W  destination register
EX_data_alu  in  DATA_W  ALU result (ignored for loads)
EX_mem_addr  in  MEM_AW  load address (ignored for ALU ops)
MEM_req  out  1  load request, held until acknowledged
MEM_addr  out  MEM_AW  load address, stable while MEM_req=1
MEM_ack  in  1  read data valid this cycle
MEM_rdata  in  DATA_W  read data
DM_addr_write  out  ADDR_W  register-file write address
DM_data_write  out  DATA_W  register-file write data
DM_sig_write  out  1  register-file write strobe, one-cycle pulse per result
ID_addr_read_a  in  ADDR_W  decode read address A
ID_addr_read_b  in  ADDR_W  decode read address B
ID_sig_hazard  out  1  decode must stall
sig_load_fault  out  1  one-cycle pulse on load timeout

Behaviour:
- Single clock sig_clk; sig_rst_n is asynchronous and active-low.
- Reset values: state IDLE; MEM_req=0; MEM_addr=0; DM_sig_write=0; DM_addr_write=0; DM_data_write=0; sig_load_fault=0; timeout counter=0; pending destination=0.
- States:
  - IDLE: EX_ready=1.
  - LOAD_WAIT: EX_ready=0.
- Transfer occurs when EX_valid & EX_ready.
- ALU transfer in IDLE:
  - Next cycle: DM_sig_write=1, DM_addr_write=EX_addr_dest, DM_data_write=EX_data_alu. Latency 1.
  - State stays IDLE, so back-to-back ALU results sustain one write per cycle.
- Load transfer in IDLE:
  - Next cycle: MEM_req=1, MEM_addr=EX_mem_addr; destination is latched; counter cleared; state goes to LOAD_WAIT.
  - DM_sig_write=0 in that cycle.
- LOAD_WAIT:
  - MEM_req and MEM_addr are held constant. The counter increments each cycle MEM_ack=0.
  - On MEM_ack=1: next cycle MEM_req=0, DM_sig_write=1, DM_addr_write=latched destination, DM_data_write=MEM_rdata captured at the ack edge. State returns to IDLE, and EX_ready=1 in that same cycle.
  - Earliest ack is the first cycle MEM_req=1.
  - If the counter reaches LOAD_TIMEOUT without an ack: next cycle MEM_req=0, DM_sig_write=1 with FAULT_DATA to the latched destination, sig_load_fault=1 for one cycle, state returns to IDLE.
  - Ack and timeout in the same cycle: ack wins and no fault is raised.
- MEM_ack in IDLE is ignored.
- Counter width is clog2(LOAD_TIMEOUT+1). It saturates and does not wrap.
- ID_sig_hazard is combinational: 1 iff state=LOAD_WAIT and (ID_addr_read_a==pending destination or ID_addr_read_b==pending destination). It is 0 in IDLE, including the writeback cycle, because the register file forwards the write port to reads.
- EX_valid=1 while EX_ready=0: the upstream stage holds its inputs. The block ignores them until IDLE.
- Reset mid-load: MEM_req drops immediately (asynchronous), no register write occurs, and no fault is raised.
- DM_sig_write is never high for two cycles off one transfer. At most one write occurs per cycle.

Decomposition:
- Shared package smolproc_pkg holds:
  - wb_state_t enum {WB_IDLE, WB_LOAD_WAIT}
  - DATA_W / ADDR_W / MEM_AW constants shared with the register file and decode stage
- No sub-module is required. The timeout counter stays inline.

Test Plan:
- Reset released, then ALU ops r1=0x12, r2=0x34, r3=0x56 on consecutive cycles -> DM_sig_write high for 3 consecutive cycles, each one cycle after acceptance, with matching addr/data; EX_ready stays 1.
- Load to r2 from 0x40, MEM_ack after 3 cycles with 0xA5 -> MEM_req high 3 cycles with MEM_addr=0x40; write r2=0xA5 one cycle after ack; EX_ready low exactly during LOAD_WAIT.
- During the above load, ID_addr_read_a=2 -> ID_sig_hazard=1; read addrs 1/3 -> 0; in the writeback cycle with addr 2 -> 0.
- Load to r1, MEM_ack never asserted -> after 15 wait cycles, write r1=0xFF plus one sig_load_fault pulse; next load accepted normally.
- Ack arriving exactly on the timeout cycle with data 0x07 -> write 0x07 and no fault.
- Assert sig_rst_n=0 two cycles into a load -> MEM_req=0 at once, no DM_sig_write, EX_ready=1 after release.

Source files
------------

// File: rtl/smolproc_pkg.sv
// Shared widths and writeback FSM state encoding, common to the register file,
// decode and writeback stages.
package smolproc_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int MEM_AW = 8;

  typedef enum logic {
    WB_IDLE,
    WB_LOAD_WAIT
  } wb_state_t;

endpackage

// File: rtl/writeback_unit.sv
// Register-file writer: ALU results written 1 cycle after accept, loads 1 cycle after MEM_ack
// or FAULT_DATA after LOAD_TIMEOUT cycles; EX_ready is low for the whole outstanding load.
module writeback_unit
  import smolproc_pkg::*;
#(
  parameter int                 DATA_W       = smolproc_pkg::DATA_W,
  parameter int                 ADDR_W       = smolproc_pkg::ADDR_W,
  parameter int                 MEM_AW       = smolproc_pkg::MEM_AW,
  parameter int                 LOAD_TIMEOUT = 15,
  parameter logic [DATA_W-1:0]  FAULT_DATA   = DATA_W'(8'hFF)
) (
  input  logic              sig_clk,
  input  logic              sig_rst_n,
  input  logic              EX_valid,
  output logic              EX_ready,
  input  logic              EX_is_load,
  input  logic [ADDR_W-1:0] EX_addr_dest,
  input  logic [DATA_W-1:0] EX_data_alu,
  input  logic [MEM_AW-1:0] EX_mem_addr,
  output logic              MEM_req,
  output logic [MEM_AW-1:0] MEM_addr,
  input  logic              MEM_ack,
  input  logic [DATA_W-1:0] MEM_rdata,
  output logic [ADDR_W-1:0] DM_addr_write,
  output logic [DATA_W-1:0] DM_data_write,
  output logic              DM_sig_write,
  input  logic [ADDR_W-1:0] ID_addr_read_a,
  input  logic [ADDR_W-1:0] ID_addr_read_b,
  output logic              ID_sig_hazard,
  output logic              sig_load_fault
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  pend_dest;
  logic               load_accept;
  logic               wr_nxt;
  logic [ADDR_W-1:0]  wr_addr_nxt;
  logic [DATA_W-1:0]  wr_data_nxt;
  logic               fault_nxt;

  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      state <= WB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    EX_ready    = 1'b0;
    load_accept = 1'b0;
    wr_nxt      = 1'b0;
    wr_addr_nxt = DM_addr_write;
    wr_data_nxt = DM_data_write;
    fault_nxt   = 1'b0;
    case (state)
      WB_IDLE: begin
        EX_ready = 1'b1;
        if (EX_valid) begin
          if (EX_is_load) begin
            load_accept = 1'b1;
            state_nxt   = WB_LOAD_WAIT;
          end else begin
            wr_nxt      = 1'b1;
            wr_addr_nxt = EX_addr_dest;
            wr_data_nxt = EX_data_alu;
          end
        end
      end
      WB_LOAD_WAIT: begin
        // An ack on the final wait cycle takes priority over the timeout.
        if (MEM_ack) begin
          wr_nxt      = 1'b1;
          wr_addr_nxt = pend_dest;
          wr_data_nxt = MEM_rdata;
          state_nxt   = WB_IDLE;
        end else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
          wr_nxt      = 1'b1;
          wr_addr_nxt = pend_dest;
          wr_data_nxt = FAULT_DATA;
          fault_nxt   = 1'b1;
          state_nxt   = WB_IDLE;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      MEM_addr       <= '0;
      pend_dest      <= '0;
      cnt            <= '0;
      DM_sig_write   <= 1'b0;
      DM_addr_write  <= '0;
      DM_data_write  <= '0;
      sig_load_fault <= 1'b0;
    end else begin
      DM_sig_write   <= wr_nxt;
      DM_addr_write  <= wr_addr_nxt;
      DM_data_write  <= wr_data_nxt;
      sig_load_fault <= fault_nxt;
      if (load_accept) begin
        MEM_addr  <= EX_mem_addr;
        pend_dest <= EX_addr_dest;
        cnt       <= '0;
      end else if (state == WB_LOAD_WAIT && !MEM_ack && cnt != CNT_W'(LOAD_TIMEOUT)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Request follows the state register, so an async reset drops it immediately.
  assign MEM_req = (state == WB_LOAD_WAIT);

  assign ID_sig_hazard = (state == WB_LOAD_WAIT) &&
                         ((ID_addr_read_a == pend_dest) || (ID_addr_read_b == pend_dest));

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU writes, loads with ack, timeout, hazard and reset mid-load.
module tb_writeback_unit;

  logic       sig_clk;
  logic       sig_rst_n;
  logic       EX_valid;
  logic       EX_ready;
  logic       EX_is_load;
  logic [1:0] EX_addr_dest;
  logic [7:0] EX_data_alu;
  logic [7:0] EX_mem_addr;
  logic       MEM_req;
  logic [7:0] MEM_addr;
  logic       MEM_ack;
  logic [7:0] MEM_rdata;
  logic [1:0] DM_addr_write;
  logic [7:0] DM_data_write;
  logic       DM_sig_write;
  logic [1:0] ID_addr_read_a;
  logic [1:0] ID_addr_read_b;
  logic       ID_sig_hazard;
  logic       sig_load_fault;

  int n_checks = 0;
  int n_pass   = 0;

  writeback_unit dut (
    .sig_clk        (sig_clk),
    .sig_rst_n      (sig_rst_n),
    .EX_valid       (EX_valid),
    .EX_ready       (EX_ready),
    .EX_is_load     (EX_is_load),
    .EX_addr_dest   (EX_addr_dest),
    .EX_data_alu    (EX_data_alu),
    .EX_mem_addr    (EX_mem_addr),
    .MEM_req        (MEM_req),
    .MEM_addr       (MEM_addr),
    .MEM_ack        (MEM_ack),
    .MEM_rdata      (MEM_rdata),
    .DM_addr_write  (DM_addr_write),
    .DM_data_write  (DM_data_write),
    .DM_sig_write   (DM_sig_write),
    .ID_addr_read_a (ID_addr_read_a),
    .ID_addr_read_b (ID_addr_read_b),
    .ID_sig_hazard  (ID_sig_hazard),
    .sig_load_fault (sig_load_fault)
  );

  initial begin
    sig_clk = 1'b0;
    forever #5 sig_clk = ~sig_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sig_clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [1:0] addr, input logic [7:0] data);
    check({tag, "_we"},   32'(DM_sig_write),  32'd1);
    check({tag, "_addr"}, 32'(DM_addr_write), 32'(addr));
    check({tag, "_data"}, 32'(DM_data_write), 32'(data));
  endtask

  int req_cycles;
  int stray_writes;

  initial begin
    sig_rst_n      = 1'b0;
    EX_valid       = 1'b0;
    EX_is_load     = 1'b0;
    EX_addr_dest   = 2'd0;
    EX_data_alu    = 8'h00;
    EX_mem_addr    = 8'h00;
    MEM_ack        = 1'b0;
    MEM_rdata      = 8'h00;
    ID_addr_read_a = 2'd0;
    ID_addr_read_b = 2'd0;

    // Reset state
    #12;
    check("rst_mem_req",  32'(MEM_req),        32'd0);
    check("rst_mem_addr", 32'(MEM_addr),       32'd0);
    check("rst_we",       32'(DM_sig_write),   32'd0);
    check("rst_waddr",    32'(DM_addr_write),  32'd0);
    check("rst_wdata",    32'(DM_data_write),  32'd0);
    check("rst_fault",    32'(sig_load_fault), 32'd0);
    check("rst_ready",    32'(EX_ready),       32'd1);
    check("rst_hazard",   32'(ID_sig_hazard),  32'd0);
    sig_rst_n = 1'b1;
    tick();

    // Back-to-back ALU results
    EX_valid = 1'b1; EX_is_load = 1'b0; EX_addr_dest = 2'd1; EX_data_alu = 8'h12;
    #1 check("alu_ready0", 32'(EX_ready), 32'd1);
    tick();
    check_write("alu_r1", 2'd1, 8'h12);
    EX_addr_dest = 2'd2; EX_data_alu = 8'h34;
    #1 check("alu_ready1", 32'(EX_ready), 32'd1);
    tick();
    check_write("alu_r2", 2'd2, 8'h34);
    EX_addr_dest = 2'd3; EX_data_alu = 8'h56;
    tick();
    check_write("alu_r3", 2'd3, 8'h56);
    EX_valid = 1'b0;
    MEM_ack = 1'b1; MEM_rdata = 8'hEE;  // ack while idle must be ignored
    tick();
    check("alu_idle_we",  32'(DM_sig_write), 32'd0);
    check("idle_ack_req", 32'(MEM_req),      32'd0);
    MEM_ack = 1'b0;

    // Load r2 from 0x40, ack on third request cycle; an ALU op waits behind it
    EX_valid = 1'b1; EX_is_load = 1'b1; EX_addr_dest = 2'd2; EX_mem_addr = 8'h40;
    tick();
    EX_is_load = 1'b0; EX_addr_dest = 2'd3; EX_data_alu = 8'h99;
    ID_addr_read_a = 2'd2; ID_addr_read_b = 2'd0;
    #1;
    check("ld_req1",    32'(MEM_req),       32'd1);
    check("ld_addr1",   32'(MEM_addr),      32'h40);
    check("ld_we1",     32'(DM_sig_write),  32'd0);
    check("ld_ready1",  32'(EX_ready),      32'd0);
    check("ld_haz_a2",  32'(ID_sig_hazard), 32'd1);
    tick();
    ID_addr_read_a = 2'd1; ID_addr_read_b = 2'd3;
    #1;
    check("ld_req2",    32'(MEM_req),       32'd1);
    check("ld_haz_13",  32'(ID_sig_hazard), 32'd0);
    check("ld_we2",     32'(DM_sig_write),  32'd0);
    ID_addr_read_a = 2'd0; ID_addr_read_b = 2'd2;
    #1 check("ld_haz_b2", 32'(ID_sig_hazard), 32'd1);
    tick();
    ID_addr_read_a = 2'd2; ID_addr_read_b = 2'd0;
    MEM_ack = 1'b1; MEM_rdata = 8'hA5;
    #1;
    check("ld_req3",    32'(MEM_req),       32'd1);
    check("ld_addr3",   32'(MEM_addr),      32'h40);
    check("ld_ready3",  32'(EX_ready),      32'd0);
    tick();
    MEM_ack = 1'b0; MEM_rdata = 8'h00;
    #1;
    check_write("ld_r2", 2'd2, 8'hA5);
    check("ld_wb_req",   32'(MEM_req),       32'd0);
    check("ld_wb_ready", 32'(EX_ready),      32'd1);
    check("ld_wb_haz",   32'(ID_sig_hazard), 32'd0);
    tick();
    check_write("held_alu_r3", 2'd3, 8'h99);
    EX_valid = 1'b0;
    tick();
    check("post_ld_we", 32'(DM_sig_write), 32'd0);

    // Load r1 with no ack: timeout after 15 wait cycles
    EX_valid = 1'b1; EX_is_load = 1'b1; EX_addr_dest = 2'd1; EX_mem_addr = 8'h80;
    tick();
    EX_valid = 1'b0;
    req_cycles = 0; stray_writes = 0;
    for (int i = 0; i < 40 && MEM_req; i++) begin
      req_cycles++;
      if (DM_sig_write || sig_load_fault) stray_writes++;
      tick();
    end
    check("to_req_cycles", 32'(req_cycles),   32'd15);
    check("to_stray",      32'(stray_writes), 32'd0);
    check_write("to_r1", 2'd1, 8'hFF);
    check("to_fault",  32'(sig_load_fault), 32'd1);
    tick();
    check("to_fault_pulse", 32'(sig_load_fault), 32'd0);
    check("to_we_pulse",    32'(DM_sig_write),   32'd0);

    // Load r3 from 0x10, ack arrives on the timeout cycle
    EX_valid = 1'b1; EX_is_load = 1'b1; EX_addr_dest = 2'd3; EX_mem_addr = 8'h10;
    tick();
    EX_valid = 1'b0;
    check("edge_addr", 32'(MEM_addr), 32'h10);
    for (int i = 1; i < 15; i++) tick();
    check("edge_req15", 32'(MEM_req), 32'd1);
    MEM_ack = 1'b1; MEM_rdata = 8'h07;
    tick();
    MEM_ack = 1'b0;
    check_write("edge_r3", 2'd3, 8'h07);
    check("edge_fault", 32'(sig_load_fault), 32'd0);
    tick();

    // Reset two cycles into a load
    EX_valid = 1'b1; EX_is_load = 1'b1; EX_addr_dest = 2'd0; EX_mem_addr = 8'h22;
    tick();
    EX_valid = 1'b0;
    tick();
    check("rl_req_before", 32'(MEM_req), 32'd1);
    #1 sig_rst_n = 1'b0;
    #1;
    check("rl_req_async", 32'(MEM_req),  32'd0);
    check("rl_addr",      32'(MEM_addr), 32'd0);
    tick();
    #3 sig_rst_n = 1'b1;
    tick();
    check("rl_we",    32'(DM_sig_write),   32'd0);
    check("rl_fault", 32'(sig_load_fault), 32'd0);
    check("rl_ready", 32'(EX_ready),       32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
